conv_layer_engine: RTL

// Parametrised KxK convolution layer core: streams one IFM pixel per accepted cycle against DSP_NO_CONV

---
 rtl/conv_layer_if.sv | 35 +++
 rtl/conv_layer_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_if.sv
// Interface bundling the conv_layer_engine stream, weight ROM, bias, OFM and
// completion signals. The feeder/ROM/RAM side uses the master modport, the
// engine uses the slave modport.
//
// Handshake: layer_en_i is a valid with no ready. The engine is ready in IDLE
// and RUN, where every cycle with layer_en_i=1 consumes ifm_i as one tap. In
// DRAIN and DONE the engine is not ready, and layer_en_i is ignored.
// sample_o is a one-cycle valid for ofm_o with no back-pressure. finish_o is
// held until the cycle after ram_feedback=1 is seen in DONE.
interface conv_layer_if #(
    parameter int WIDTH       = 16,
    parameter int DSP_NO_CONV = 32,
    parameter int ADDR_W      = 11
);
    logic                           layer_en_i;
    logic [WIDTH-1:0]               ifm_i;
    logic [ADDR_W-1:0]              weight_addr_o;
    logic [DSP_NO_CONV*WIDTH-1:0]   weight_i;
    logic [DSP_NO_CONV*2*WIDTH-1:0] bias_i;
    logic                           ram_feedback;
    logic                           sample_o;
    logic                           finish_o;
    logic [DSP_NO_CONV*WIDTH-1:0]   ofm_o;
    logic [1:0]                     dbg_state;

    modport master (
        output layer_en_i, ifm_i, weight_i, bias_i, ram_feedback,
        input  weight_addr_o, sample_o, finish_o, ofm_o, dbg_state
    );

    modport slave (
        input  layer_en_i, ifm_i, weight_i, bias_i, ram_feedback,
        output weight_addr_o, sample_o, finish_o, ofm_o, dbg_state
    );
endinterface

// File: rtl/conv_layer_engine.sv
// KxK convolution layer core. It accepts one IFM tap per enabled cycle and
// multiplies it against DSP_NO_CONV weight lanes. It accumulates
// TAPS = KERNEL_DIM^2*CHIN taps per output pixel, then adds bias, applies
// ReLU and requantises the result.
// Pipeline after the accepted cycle T:
//   - ROM_LATENCY delay stages for the ifm and tags (weight_i is valid at T+L)
//   - a weight/ifm register stage
//   - the MAC stage
//   - the output register
// sample_o therefore fires at T+L+3.
// Optional build macro CONV_SATURATE_EN: positive overflow saturates to
// 2^(WIDTH-1)-1 instead of silently truncating the upper bits.
// dbg_state exposes the FSM: 0=IDLE 1=RUN 2=DRAIN 3=DONE.
module conv_layer_engine #(
    parameter int WIDTH       = 16,
    parameter int FRAC        = 14,
    parameter int DSP_NO_CONV = 32,
    parameter int CHIN        = 128,
    parameter int KERNEL_DIM  = 3,
    parameter int WOUT        = 32,
    parameter int ROM_LATENCY = 1,
    parameter int ACC_W       = 2*WIDTH + $clog2(KERNEL_DIM*KERNEL_DIM*CHIN)
) (
    input logic         clk,
    input logic         rst,
    conv_layer_if.slave bus
);
    localparam int TAPS   = KERNEL_DIM*KERNEL_DIM*CHIN;
    localparam int PIXELS = WOUT*WOUT;
    localparam int ADDR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int PW     = 2*WIDTH;
    localparam int RW     = ACC_W + 1;
    localparam int L      = ROM_LATENCY;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_W-1:0] tap_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic              accept, tap_last, pix_last;

    // Delay line matching the weight ROM latency.
    logic             dl_valid [L];
    logic             dl_first [L];
    logic             dl_last  [L];
    logic             dl_end   [L];
    logic [WIDTH-1:0] dl_ifm   [L];

    // Weight/ifm register stage.
    logic                         s1_valid, s1_first, s1_last, s1_end;
    logic [WIDTH-1:0]             s1_ifm;
    logic [DSP_NO_CONV*WIDTH-1:0] s1_w;

    // MAC stage.
    logic [ACC_W-1:0] acc      [DSP_NO_CONV];
    logic [ACC_W-1:0] prod_ext [DSP_NO_CONV];
    logic             mac_done, mac_end;

    // Requantisation.
    logic [RW-1:0]    r_lane [DSP_NO_CONV];
    logic [WIDTH-1:0] q_lane [DSP_NO_CONV];
    logic             out_end;

    // Taps are consumed only while the engine is taking a new image.
    assign accept   = bus.layer_en_i && ((state == S_IDLE) || (state == S_RUN));
    assign tap_last = (tap_cnt == ADDR_W'(TAPS - 1));
    assign pix_last = (pix_cnt == PIX_W'(PIXELS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; DRAIN ends on the sample of the image's last pixel.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = (tap_last && pix_last) ? S_DRAIN : S_RUN;
            S_RUN:   if (accept && tap_last && pix_last) state_nxt = S_DRAIN;
            S_DRAIN: if (out_end) state_nxt = S_DONE;
            S_DONE:  if (bus.ram_feedback) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM-derived outputs and the ROM address.
    always_comb begin
        bus.finish_o      = (state == S_DONE);
        bus.weight_addr_o = tap_cnt;
        bus.dbg_state     = state;
    end

    // Tap/pixel counters: advance only on accepted taps, wrapping so that the
    // next image starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt <= '0;
            pix_cnt <= '0;
        end else if (accept) begin
            if (tap_last) begin
                tap_cnt <= '0;
                pix_cnt <= pix_last ? '0 : pix_cnt + PIX_W'(1);
            end else begin
                tap_cnt <= tap_cnt + ADDR_W'(1);
            end
        end
    end

    // Carry ifm and first/last/end tags alongside the weight ROM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < L; i++) begin
                dl_valid[i] <= 1'b0;
                dl_first[i] <= 1'b0;
                dl_last[i]  <= 1'b0;
                dl_end[i]   <= 1'b0;
                dl_ifm[i]   <= '0;
            end
        end else begin
            dl_valid[0] <= accept;
            dl_first[0] <= (tap_cnt == '0);
            dl_last[0]  <= tap_last;
            dl_end[0]   <= tap_last && pix_last;
            dl_ifm[0]   <= bus.ifm_i;
            for (int i = 1; i < L; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_first[i] <= dl_first[i-1];
                dl_last[i]  <= dl_last[i-1];
                dl_end[i]   <= dl_end[i-1];
                dl_ifm[i]   <= dl_ifm[i-1];
            end
        end
    end

    // Register the weight word together with its matching ifm and tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_end   <= 1'b0;
            s1_ifm   <= '0;
            s1_w     <= '0;
        end else begin
            s1_valid <= dl_valid[L-1];
            s1_first <= dl_first[L-1];
            s1_last  <= dl_last[L-1];
            s1_end   <= dl_end[L-1];
            s1_ifm   <= dl_ifm[L-1];
            s1_w     <= bus.weight_i;
        end
    end

    // Signed per-lane products, sign-extended to the accumulator width.
    always_comb begin
        for (int i = 0; i < DSP_NO_CONV; i++) begin
            logic [PW-1:0] a_ext, b_ext, p;
            a_ext       = {{WIDTH{s1_ifm[WIDTH-1]}}, s1_ifm};
            b_ext       = {{WIDTH{s1_w[i*WIDTH+WIDTH-1]}}, s1_w[i*WIDTH +: WIDTH]};
            p           = a_ext * b_ext;
            prod_ext[i] = {{(ACC_W-PW){p[PW-1]}}, p};
        end
    end

    // MAC. The first tag restarts the sum, so a new pixel can enter while
    // the previous one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DSP_NO_CONV; i++) acc[i] <= '0;
            mac_done <= 1'b0;
            mac_end  <= 1'b0;
        end else begin
            mac_done <= s1_valid && s1_last;
            mac_end  <= s1_valid && s1_last && s1_end;
            if (s1_valid) begin
                for (int i = 0; i < DSP_NO_CONV; i++)
                    acc[i] <= s1_first ? prod_ext[i] : acc[i] + prod_ext[i];
            end
        end
    end

    // Bias add, ReLU and requantisation. The sum is one bit wider than acc,
    // so the bias add cannot overflow.
    always_comb begin
        for (int i = 0; i < DSP_NO_CONV; i++) begin
            logic [PW-1:0] b;
            b         = bus.bias_i[i*PW +: PW];
            r_lane[i] = {acc[i][ACC_W-1], acc[i]} + {{(RW-PW){b[PW-1]}}, b};
            if (r_lane[i][RW-1])
                q_lane[i] = '0;
`ifdef CONV_SATURATE_EN
            else if (|r_lane[i][RW-2:FRAC+WIDTH-1])
                q_lane[i] = {1'b0, {(WIDTH-1){1'b1}}};
`endif
            else
                q_lane[i] = {1'b0, r_lane[i][FRAC+WIDTH-2:FRAC]};
        end
    end

    // Output register: sample pulse and OFM update; ofm_o holds between
    // samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sample_o <= 1'b0;
            bus.ofm_o    <= '0;
            out_end      <= 1'b0;
        end else begin
            bus.sample_o <= mac_done;
            out_end      <= mac_end;
            if (mac_done) begin
                for (int i = 0; i < DSP_NO_CONV; i++)
                    bus.ofm_o[i*WIDTH +: WIDTH] <= q_lane[i];
            end
        end
    end
endmodule
